multicycle_control: RTL and testbench

- Control FSM for the multicycle RV32I-subset core that replaces the single-cycle control path.
- Sequences one shared memory (instruction + data), one ALU and the PC/IR/OldPC/ALUOut/Data holding registers over 3–5 cycles per instruction.
- Stalls on a memory ready handshake and traps illegal instructions.

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_control.sv | 164 ++++++++++++++++
 tb/tb_multicycle_control.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and encodings for the RV32I-subset control paths.
// Opcodes, ALU/select encodings and the multicycle FSM state type.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_BEQ,
        S_JAL,
        S_ERROR
    } state_t;

    localparam logic [6:0] OP_LW  = 7'd3;
    localparam logic [6:0] OP_SW  = 7'd35;
    localparam logic [6:0] OP_R   = 7'd51;
    localparam logic [6:0] OP_I   = 7'd19;
    localparam logic [6:0] OP_BEQ = 7'd99;
    localparam logic [6:0] OP_JAL = 7'd111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    // Only add/sub, slt, or, and are implemented for R/I-type.
    function automatic logic funct3_supported(input logic [2:0] f3);
        return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from ALUOp/funct3; shared by single- and multicycle control.
// Purely combinational, no backpressure.
module alu_decoder
    import cpu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op_b5,
    input  logic       i_funct7_b5,
    output logic [2:0] o_alu_control
);

    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // addi must not turn into sub when its immediate has bit 10 set
                    3'b000:  o_alu_control = (i_op_b5 && i_funct7_b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_alu_control = ALU_SLT;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I-subset control FSM: 3-5 cycles per instruction.
// Stalls in FETCH/MEMREAD/MEMWRITE until mem_ready; traps illegal opcodes.
module multicycle_control
    import cpu_pkg::*;
#(
    parameter bit RESET_ON_ILLEGAL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7_bit5,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal
);

    state_t     r_state;
    state_t     w_next_state;
    logic       r_illegal;
    logic [1:0] w_alu_op;
    logic       w_pc_write;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_reg_write;
    logic       w_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Set on entry so the flag is already visible in the ERROR cycle.
            if (w_next_state == S_ERROR)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_R:    w_next_state = funct3_supported(funct3) ? S_EXECUTER : S_ERROR;
                    OP_I:    w_next_state = funct3_supported(funct3) ? S_EXECUTEI : S_ERROR;
                    OP_BEQ:  w_next_state = S_BEQ;
                    OP_JAL:  w_next_state = S_JAL;
                    default: w_next_state = S_ERROR;
                endcase
            end
            S_MEMADR:   w_next_state = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) w_next_state = S_MEMWB;
            S_MEMWB:    w_next_state = S_FETCH;
            S_MEMWRITE: if (mem_ready) w_next_state = S_FETCH;
            S_EXECUTER: w_next_state = S_ALUWB;
            S_EXECUTEI: w_next_state = S_ALUWB;
            S_ALUWB:    w_next_state = S_FETCH;
            S_BEQ:      w_next_state = S_FETCH;
            S_JAL:      w_next_state = S_ALUWB;
            S_ERROR:    w_next_state = RESET_ON_ILLEGAL ? S_FETCH : S_ERROR;
            default:    w_next_state = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_done      = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RS2;
        ImmSrc      = IMM_I;
        w_alu_op    = ALUOP_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURESULT;
                w_ir_write = mem_ready;
                w_pc_write = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (op == OP_SW) ? IMM_S : IMM_I;
            end
            S_MEMREAD:  AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                w_done      = mem_ready;
            end
            S_EXECUTER: begin
                ALUSrcA  = SRCA_RS1;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA  = SRCA_RS1;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RS1;
                w_alu_op   = ALUOP_SUB;
                w_pc_write = Zero;
                w_done     = 1'b1;
            end
            S_JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ImmSrc     = IMM_J;
                w_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op_b5       (op[5]),
        .i_funct7_b5   (funct7_bit5),
        .o_alu_control (ALUControl)
    );

    // Enables are gated by reset directly so they drop without waiting for a clock.
    assign PCWrite    = rst & w_pc_write;
    assign MemWrite   = rst & w_mem_write;
    assign IRWrite    = rst & w_ir_write;
    assign RegWrite   = rst & w_reg_write;
    assign instr_done = rst & w_done;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control against a per-instruction cycle-trace model.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_bit5 = 1'b0;
    logic       Zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int last_done = -1;
    int n_done   = 0;

    multicycle_control #(.RESET_ON_ILLEGAL(1'b0)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_bit5(funct7_bit5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .instr_done(instr_done), .illegal(illegal)
    );

    always #5 clk = ~clk;

    wire [17:0] outs = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                        ALUControl, ImmSrc, RegWrite, instr_done, illegal};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Expected output vector, same field order as 'outs'.
    function automatic logic [17:0] ov(input logic pcw, input logic adr, input logic mw,
            input logic irw, input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
            input logic [2:0] alu, input logic [1:0] imm, input logic rw, input logic dn,
            input logic ill);
        return {pcw, adr, mw, irw, rs, sa, sb, alu, imm, rw, dn, ill};
    endfunction

    function automatic logic [17:0] e_fetch(input logic mr);
        return ov(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 3'b000, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [17:0] e_decode();
        return ov(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 2'b10, 0, 0, 0);
    endfunction
    function automatic logic [17:0] e_error();
        return ov(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0, 0, 1);
    endfunction

    // ISA-level ALU op for R/I-type instructions.
    function automatic logic [2:0] exp_alu(input logic [6:0] o, input logic [2:0] f3, input logic b30);
        case (f3)
            3'b000:  return (o == 7'd51 && b30) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            default: return 3'b010;
        endcase
    endfunction

    function automatic bit is_legal(input logic [6:0] o, input logic [2:0] f3);
        bit f3ok = (f3 == 0) || (f3 == 2) || (f3 == 6) || (f3 == 7);
        case (o)
            7'd3, 7'd35, 7'd99, 7'd111: return 1'b1;
            7'd51, 7'd19:               return f3ok;
            default:                    return 1'b0;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive at posedge+1, compare at negedge, advance to next posedge+1.
    task automatic step(input logic mr, input logic z, input logic [17:0] exp, input string tag);
        mem_ready = mr;
        Zero      = z;
        @(negedge clk);
        check_eq(tag, 32'(outs), 32'(exp));
        if (instr_done === 1'b1) begin
            last_done = cyc;
            n_done++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_ready = 1'b0;
        Zero = 1'b0;
        #1;
        check_eq("reset_outs", 32'(outs), 32'(e_fetch(1'b0)));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Waits < 0 mean random wait counts; zsel < 0 means random Zero for beq.
    task automatic run_instr(input logic [31:0] ir, input int fwait, input int mwait, input int zsel);
        int start;
        int stalls;
        int nw;
        int base;
        logic zv;
        logic [2:0] alu;
        op = ir[6:0];
        funct3 = ir[14:12];
        funct7_bit5 = ir[30];
        start = cyc;
        n_done = 0;
        base = 0;
        nw = (fwait < 0) ? int'($urandom_range(0, 2)) : fwait;
        stalls = nw;
        for (int i = 0; i < nw; i++) step(1'b0, rb(), e_fetch(1'b0), "fetch_wait");
        step(1'b1, rb(), e_fetch(1'b1), "fetch");
        step(rb(), rb(), e_decode(), "decode");
        alu = exp_alu(ir[6:0], ir[14:12], ir[30]);
        if (!is_legal(ir[6:0], ir[14:12])) begin
            for (int i = 0; i < 4; i++) step(rb(), rb(), e_error(), "error_hold");
            do_reset();
            return;
        end
        nw = (mwait < 0) ? int'($urandom_range(0, 2)) : mwait;
        case (ir[6:0])
            7'd3: begin
                base = 5;
                stalls += nw;
                step(rb(), rb(), ov(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b00,0,0,0), "lw_memadr");
                for (int i = 0; i < nw; i++)
                    step(1'b0, rb(), ov(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0), "memread_wait");
                step(1'b1, rb(), ov(0,1,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0), "memread");
                step(rb(), rb(), ov(0,0,0,0,2'b01,2'b00,2'b00,3'b000,2'b00,1,1,0), "memwb");
            end
            7'd35: begin
                base = 4;
                stalls += nw;
                step(rb(), rb(), ov(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0,0), "sw_memadr");
                for (int i = 0; i < nw; i++)
                    step(1'b0, rb(), ov(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,0,0), "memwrite_wait");
                step(1'b1, rb(), ov(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,1,0), "memwrite");
            end
            7'd51, 7'd19: begin
                base = 4;
                if (ir[6:0] == 7'd51)
                    step(rb(), rb(), ov(0,0,0,0,2'b00,2'b10,2'b00,alu,2'b00,0,0,0), "executer");
                else
                    step(rb(), rb(), ov(0,0,0,0,2'b00,2'b10,2'b01,alu,2'b00,0,0,0), "executei");
                step(rb(), rb(), ov(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,1,0), "aluwb");
            end
            7'd99: begin
                base = 3;
                zv = (zsel < 0) ? rb() : zsel[0];
                step(rb(), zv, ov(zv,0,0,0,2'b00,2'b10,2'b00,3'b001,2'b00,0,1,0), "beq");
            end
            default: begin
                base = 4;
                step(rb(), rb(), ov(1,0,0,0,2'b00,2'b01,2'b10,3'b000,2'b11,0,0,0), "jal");
                step(rb(), rb(), ov(0,0,0,0,2'b00,2'b00,2'b00,3'b000,2'b00,1,1,0), "jal_aluwb");
            end
        endcase
        check_eq("latency", 32'(last_done - start + 1), 32'(base + stalls));
        check_eq("done_count", 32'(n_done), 32'd1);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ir = $urandom;
        logic [2:0] good [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
        logic [2:0] bad  [4] = '{3'd1, 3'd3, 3'd4, 3'd5};
        logic [6:0] ops  [6] = '{7'd3, 7'd35, 7'd51, 7'd19, 7'd99, 7'd111};
        int k = $urandom_range(0, 9);
        if (k < 6) begin
            ir[6:0] = ops[k];
            if (k == 2 || k == 3) ir[14:12] = good[$urandom_range(0, 3)];
        end else if (k < 8) begin
            ir[6:0] = ($urandom_range(0, 1) == 1) ? 7'd51 : 7'd19;
            ir[14:12] = bad[$urandom_range(0, 3)];
        end else begin
            ir[6:0] = 7'($urandom);
            while (is_legal(ir[6:0], 3'd0)) ir[6:0] = 7'($urandom);
        end
        return ir;
    endfunction

    initial begin
        #2;
        do_reset();
        run_instr(32'h3e802403, 0, 0, -1);              // lw, no waits: 5 cycles
        run_instr(32'h00812023, 0, 3, -1);              // sw, 3 write waits: 7 cycles
        run_instr(32'hfe0002e3, 0, 0, 1);               // beq taken
        run_instr(32'hfe0002e3, 0, 0, 0);               // beq not taken
        run_instr(32'h40940533, 0, 0, -1);              // sub
        run_instr(32'h00942533, 0, 0, -1);              // slt
        run_instr(32'h00946533, 0, 0, -1);              // or
        run_instr(32'h00947533, 0, 0, -1);              // and
        run_instr(32'h40000513, 0, 0, -1);              // addi with IR[30]=1
        run_instr(32'h0080006f, 1, 0, -1);              // jal
        run_instr(32'h0000007f, 0, 0, -1);              // illegal opcode, held, then reset

        // Asynchronous reset in the middle of a stalled store.
        op = 7'd35; funct3 = 3'b010; funct7_bit5 = 1'b0;
        step(1'b1, 1'b0, e_fetch(1'b1), "ar_fetch");
        step(1'b0, 1'b0, e_decode(), "ar_decode");
        step(1'b0, 1'b0, ov(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0,0), "ar_memadr");
        mem_ready = 1'b0;
        @(negedge clk);
        check_eq("ar_memwrite_high", 32'(MemWrite), 32'd1);
        #2 rst = 1'b0;
        #1 check_eq("ar_async_drop", 32'(outs), 32'(e_fetch(1'b0)));
        @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1, 1'b0, e_fetch(1'b1), "ar_after_fetch");
        step(1'b0, 1'b0, e_decode(), "ar_after_decode");
        step(1'b1, 1'b0, ov(0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'b01,0,0,0), "ar_after_memadr");
        step(1'b1, 1'b0, ov(0,1,1,0,2'b00,2'b00,2'b00,3'b000,2'b00,0,1,0), "ar_after_memwrite");

        for (int n = 0; n < 80; n++) run_instr(rand_instr(), -1, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
